// File: rtl/sisc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sisc_pkg : shared types and defaults for the SISC memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package sisc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  // Requester IDs double as bit positions in the request/grant vectors
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int unsigned C_DEF_AW      = 16;
  localparam int unsigned C_DEF_DW      = 32;
  localparam int unsigned C_DEF_MEM_LAT = 2;

endpackage : sisc_pkg
`default_nettype wire

// File: rtl/sisc_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sisc_rr_pick : 2-way round-robin picker, one-hot grant, favours !i_last on tie
// Rev 1.0
// ----------------------------------------------------------------------------
module sisc_rr_pick
  import sisc_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = (i_last == REQ_D) ? 2'b01 : 2'b10;
    end
  end

endmodule : sisc_rr_pick
`default_nettype wire

// File: rtl/sisc_mem_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sisc_mem_arb : fetch / data arbiter and fixed-latency sequencer for one memory
// Rev 1.0
// ----------------------------------------------------------------------------
module sisc_mem_arb
  import sisc_pkg::*;
#(
  parameter int unsigned AW      = C_DEF_AW,
  parameter int unsigned DW      = C_DEF_DW,
  parameter int unsigned MEM_LAT = C_DEF_MEM_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_d_done,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam logic [3:0] C_CNT_LOAD = 4'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic          r_last;
  logic          r_owner;
  logic          r_if_rvalid;
  logic          r_d_done;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_issue_rd;
  logic          w_d_wr;
  logic          w_rd_done;

  // Requests are masked outside IDLE so nothing can be granted mid-read
  assign w_req = (r_state == ST_IDLE) ? {i_d_req, i_if_req} : 2'b00;

  sisc_rr_pick u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_d_wr     = w_gnt[REQ_D] & i_d_we;
  assign w_issue_rd = w_gnt[REQ_IF] | (w_gnt[REQ_D] & ~i_d_we);
  assign w_rd_done  = (r_state == ST_RD_WAIT) && (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_issue_rd) w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (w_rd_done)  w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt[REQ_IF]) begin
      o_mem_addr = i_if_addr;
    end else if (w_gnt[REQ_D]) begin
      o_mem_addr = i_d_addr;
      if (i_d_we) o_mem_wdata = i_d_wdata;
    end
  end

  assign o_if_gnt = w_gnt[REQ_IF];
  assign o_d_gnt  = w_gnt[REQ_D];
  assign o_mem_en = |w_gnt;
  assign o_mem_we = w_d_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_last      <= REQ_D;
      r_owner     <= REQ_IF;
      r_if_rvalid <= 1'b0;
      r_d_done    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= w_rd_done && (r_owner == REQ_IF);
      // Writes complete the cycle after issue; reads when the counter expires
      r_d_done    <= (w_rd_done && (r_owner == REQ_D)) || w_d_wr;
      if (|w_gnt) r_last <= w_gnt[REQ_D];
      if (w_issue_rd) begin
        r_cnt   <= C_CNT_LOAD;
        r_owner <= w_gnt[REQ_D];
      end else if ((r_state == ST_RD_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd_done) begin
        if (r_owner == REQ_IF) r_if_rdata <= i_mem_rdata;
        else                   r_d_rdata  <= i_mem_rdata;
      end
    end
  end

  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_done    = r_d_done;
  assign o_d_rdata   = r_d_rdata;

endmodule : sisc_mem_arb
`default_nettype wire

// File: tb/tb_sisc_mem_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sisc_mem_arb : directed self-checking bench for sisc_mem_arb, MEM_LAT = 2
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sisc_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_done;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sisc_mem_arb #(.AW(16), .DW(32), .MEM_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_gnt    (if_gnt),
    .o_if_rvalid (if_rvalid),
    .o_if_rdata  (if_rdata),
    .i_d_req     (d_req),
    .i_d_we      (d_we),
    .i_d_addr    (d_addr),
    .i_d_wdata   (d_wdata),
    .o_d_gnt     (d_gnt),
    .o_d_done    (d_done),
    .o_d_rdata   (d_rdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; checks run 1 ns later, well before the rising edge
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state ----------------
    nxt(); nxt();
    #1;
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_done",    32'(d_done),    32'd0);
    chk("rst_if_rdata",  if_rdata,       32'd0);
    chk("rst_d_rdata",   d_rdata,        32'd0);
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    rst = 1'b0;
    nxt();

    // ---------------- reset during a fetch read ----------------
    mem_rdata = 32'hBAD0BAD0;
    if_req = 1'b1; if_addr = 16'h0030;          // T
    #1 chk("ra_if_gnt", 32'(if_gnt), 32'd1);
    nxt();                                       // T+1
    if_req = 1'b0; rst = 1'b1;
    nxt();                                       // T+2
    rst = 1'b0;
    if_req = 1'b1;
    #1 chk("ra_idle_gnt", 32'(if_gnt), 32'd1);  // IDLE again: immediate grant visible
    if_req = 1'b0;
    #1 chk("ra_drop_mem_en", 32'(mem_en), 32'd0);
    nxt();                                       // T+3
    #1;
    chk("ra_no_rvalid", 32'(if_rvalid), 32'd0);
    chk("ra_if_rdata",  if_rdata,       32'd0);
    nxt();

    // ---------------- data write, back-to-back ----------------
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h12345678;  // T
    #1;
    chk("wr_d_gnt",     32'(d_gnt),     32'd1);
    chk("wr_mem_en",    32'(mem_en),    32'd1);
    chk("wr_mem_we",    32'(mem_we),    32'd1);
    chk("wr_mem_addr",  32'(mem_addr),  32'h0020);
    chk("wr_mem_wdata", mem_wdata,      32'h12345678);
    chk("wr_if_gnt",    32'(if_gnt),    32'd0);
    nxt();                                       // T+1
    d_addr = 16'h0024; d_wdata = 32'hCAFEF00D;
    #1;
    chk("wr_done1",     32'(d_done),    32'd1);
    chk("wr_gnt2",      32'(d_gnt),     32'd1);
    chk("wr_addr2",     32'(mem_addr),  32'h0024);
    nxt();                                       // T+2
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("wr_done2",     32'(d_done),    32'd1);
    chk("wr_idle_en",   32'(mem_en),    32'd0);
    chk("wr_idle_wdata", mem_wdata,     32'd0);
    nxt();                                       // T+3
    #1 chk("wr_done_low", 32'(d_done), 32'd0);

    // ---------------- single fetch ----------------
    mem_rdata = 32'h0;
    if_req = 1'b1; if_addr = 16'h0010;           // T
    #1;
    chk("sf_if_gnt",   32'(if_gnt),   32'd1);
    chk("sf_mem_en",   32'(mem_en),   32'd1);
    chk("sf_mem_we",   32'(mem_we),   32'd0);
    chk("sf_mem_addr", 32'(mem_addr), 32'h0010);
    nxt();                                       // T+1
    if_req = 1'b0;
    #1 chk("sf_rv_t1", 32'(if_rvalid), 32'd0);
    nxt();                                       // T+2
    mem_rdata = 32'hDEADBEEF;
    #1 chk("sf_rv_t2", 32'(if_rvalid), 32'd0);
    nxt();                                       // T+3
    mem_rdata = 32'h0;
    #1;
    chk("sf_rv_t3",    32'(if_rvalid), 32'd1);
    chk("sf_rdata_t3", if_rdata,       32'hDEADBEEF);
    chk("sf_done_t3",  32'(d_done),    32'd0);
    nxt();                                       // T+4
    #1;
    chk("sf_rv_t4",    32'(if_rvalid), 32'd0);
    chk("sf_rdata_t4", if_rdata,       32'hDEADBEEF);

    // ---------------- tie after reset ----------------
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h0100;
    d_req = 1'b1;  d_we = 1'b0; d_addr = 16'h0200;   // T
    #1;
    chk("tie_if_gnt",   32'(if_gnt),   32'd1);
    chk("tie_d_gnt",    32'(d_gnt),    32'd0);
    chk("tie_addr",     32'(mem_addr), 32'h0100);
    nxt();                                       // T+1
    if_req = 1'b0;
    #1;
    chk("tie_wait_d_gnt", 32'(d_gnt), 32'd0);
    chk("tie_wait_en",    32'(mem_en), 32'd0);
    nxt();                                       // T+2
    mem_rdata = 32'h11112222;
    #1 chk("tie_wait2_d_gnt", 32'(d_gnt), 32'd0);
    nxt();                                       // T+3
    mem_rdata = 32'h0;
    if_req = 1'b1; if_addr = 16'h0104;
    #1;
    chk("tie_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("tie_if_rdata",  if_rdata,       32'h11112222);
    chk("tie_d_gnt_t3",  32'(d_gnt),     32'd1);
    chk("tie_if_gnt_t3", 32'(if_gnt),    32'd0);
    chk("tie_addr_t3",   32'(mem_addr),  32'h0200);
    nxt();                                       // T+4
    d_req = 1'b0;
    #1 chk("tie_if_gnt_t4", 32'(if_gnt), 32'd0);
    nxt();                                       // T+5
    mem_rdata = 32'h33334444;
    nxt();                                       // T+6
    mem_rdata = 32'h0;
    #1;
    chk("tie_d_done",    32'(d_done),   32'd1);
    chk("tie_d_rdata",   d_rdata,       32'h33334444);
    chk("tie_if_gnt_t6", 32'(if_gnt),   32'd1);
    chk("tie_addr_t6",   32'(mem_addr), 32'h0104);
    nxt();                                       // T+7
    if_req = 1'b0;
    nxt();                                       // T+8
    mem_rdata = 32'h55556666;
    nxt();                                       // T+9
    mem_rdata = 32'h0;
    #1;
    chk("tie_f2_rvalid", 32'(if_rvalid), 32'd1);
    chk("tie_f2_rdata",  if_rdata,       32'h55556666);
    nxt();

    // ---------------- held back-to-back fetches ----------------
    mem_rdata = 32'h77778888;
    if_req = 1'b1; if_addr = 16'h0300;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("b2b_gnt_%0d", k), 32'(if_gnt), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_done_%0d", k), 32'(d_done), 32'd0);
      if (k == 6) if_req = 1'b0;
      nxt();
    end
    nxt(); nxt();
    #1 chk("b2b_rdata", if_rdata, 32'h77778888);

    // ---------------- data read ----------------
    mem_rdata = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0044;   // T
    #1;
    chk("dr_d_gnt",   32'(d_gnt),    32'd1);
    chk("dr_mem_we",  32'(mem_we),   32'd0);
    chk("dr_addr",    32'(mem_addr), 32'h0044);
    nxt();                                       // T+1
    d_req = 1'b0;
    #1 chk("dr_done_t1", 32'(d_done), 32'd0);
    nxt();                                       // T+2
    mem_rdata = 32'h0000ABCD;
    #1 chk("dr_done_t2", 32'(d_done), 32'd0);
    nxt();                                       // T+3
    mem_rdata = 32'h0;
    #1;
    chk("dr_done_t3",   32'(d_done),    32'd1);
    chk("dr_d_rdata",   d_rdata,        32'h0000ABCD);
    chk("dr_if_rdata",  if_rdata,       32'h77778888);
    chk("dr_if_rvalid", 32'(if_rvalid), 32'd0);
    nxt();
    #1 chk("dr_done_t4", 32'(d_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sisc_mem_arb
`default_nettype wire
